// File: rtl/shift_mult_ctrl.sv
// Purpose : control FSM for a WIDTH-iteration shift/add multiplier (LOAD, then TEST/SHIFT pairs, then DONE).
// Latency : start sampled in IDLE at cycle k -> LOAD at k+1, done pulse at k+2+2*WIDTH.
// Backpr. : none; start is only looked at in IDLE, so a start while busy is dropped rather than queued.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-low reset
//   start      begin one multiply (sampled only in IDLE)
//   lsb_in     LSB of the multiplier shift register
//   mplr_zero  multiplier register is all zeros (observed only with SHIFT_MULT_EARLY_TERM_EN)
//   ld         parallel load of the multiplier/multiplicand registers
//   shr_en     shift the multiplier right
//   shl_en     shift the multiplicand left (always equal to shr_en)
//   acc_clr    clear the accumulator
//   acc_add    add the multiplicand into the accumulator (only output that is not a pure state decode)
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
//   cnt        registered iteration counter; reads WIDTH in DONE after a full run
//
// Build option
//   SHIFT_MULT_EARLY_TERM_EN : when defined, TEST with mplr_zero=1 jumps straight to DONE
//                              without adding or shifting; cnt keeps its current value.
//                              When undefined, mplr_zero has no effect.

module shift_mult_ctrl #(
   parameter int WIDTH = 16   // operand width and iteration count, 2..32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   lsb_in,
   input  logic                   mplr_zero,
   output logic                   ld,
   output logic                   shr_en,
   output logic                   shl_en,
   output logic                   acc_clr,
   output logic                   acc_add,
   output logic                   busy,
   output logic                   done,
   output logic [$clog2(WIDTH):0] cnt
);

   localparam int CW = $clog2(WIDTH) + 1;

   // Last value cnt holds while in SHIFT before the run completes.
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_TEST  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q,   cnt_d;

   // Moore outputs are registered: each one is a decode of the next state,
   // so the flop output is exactly the decode of the current state.
   logic            ld_q,      ld_d;
   logic            shift_q,   shift_d;
   logic            acc_clr_q, acc_clr_d;
   logic            busy_q,    busy_d;
   logic            done_q,    done_d;

   // Early-exit qualifier seen in TEST; constant 0 when the option is off.
   logic            early_exit;

`ifdef SHIFT_MULT_EARLY_TERM_EN
   assign early_exit = mplr_zero;
`else
   assign early_exit = 1'b0;
   // mplr_zero is deliberately not observed in this build.
   logic  unused_mplr_zero;
   assign unused_mplr_zero = mplr_zero;
`endif

   // ------------------------------------------------------------------
   // Next-state and counter logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            cnt_d   = '0;
            state_d = ST_TEST;
         end

         ST_TEST: begin
            // With early exit, the multiplier has no set bits left, so the
            // accumulator already holds the product; cnt is left untouched.
            if (early_exit) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_TEST;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Registered Moore output decode (from next state)
   // ------------------------------------------------------------------
   always_comb begin
      ld_d      = (state_d == ST_LOAD);
      acc_clr_d = (state_d == ST_LOAD);
      shift_d   = (state_d == ST_SHIFT);
      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_DONE);
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         ld_q      <= 1'b0;
         shift_q   <= 1'b0;
         acc_clr_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ld_q      <= ld_d;
         shift_q   <= shift_d;
         acc_clr_q <= acc_clr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign ld      = ld_q;
   assign acc_clr = acc_clr_q;
   // One shared flop guarantees the two shift strobes can never diverge.
   assign shr_en  = shift_q;
   assign shl_en  = shift_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign cnt     = cnt_q;

   // acc_add follows lsb_in combinationally, and only in TEST, which keeps it
   // exclusive with ld (LOAD) and the shift strobes (SHIFT).
   assign acc_add = (state_q == ST_TEST) && lsb_in && !early_exit;

   // ------------------------------------------------------------------
   // Invariants
   // ------------------------------------------------------------------
   a_strobe_excl : assert property (@(posedge clk) disable iff (!rst)
      !((ld_q && shift_q) || (ld_q && acc_add) || (shift_q && acc_add)));

   a_busy_done : assert property (@(posedge clk) disable iff (!rst)
      done_q |-> busy_q);

endmodule

// File: doc/shift_mult_ctrl.md
SHIFT_MULT_CTRL -- requirements
Module: shift_mult_ctrl

Interface
REQ-001 Parameter: WIDTH, default 16, operand width and number of shift/add iterations; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous active-low reset; sampled on rising clk edge.
REQ-004 Port: start  input  1  request to begin one multiply; sampled only in IDLE.
REQ-005 Port: lsb_in  input  1  LSB_out of the multiplier shift register.
REQ-006 Port: mplr_zero  input  1  high when the multiplier register holds all zeros; used only with EARLY_TERM_EN.
REQ-007 Port: ld  output  1  parallel-load strobe to the multiplier and multiplicand shift registers.
REQ-008 Port: shr_en  output  1  shift-right strobe to the multiplier register.
REQ-009 Port: shl_en  output  1  shift-left strobe to the multiplicand register.
REQ-010 Port: acc_clr  output  1  clear strobe to the accumulator.
REQ-011 Port: acc_add  output  1  add-multiplicand-to-accumulator strobe.
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: done  output  1  one-cycle completion pulse.
REQ-014 Port: cnt  output  $clog2(WIDTH)+1  iteration counter, registered.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, TEST, SHIFT, DONE; state encoding is free.
REQ-016 IDLE: start=1 -> LOAD; start=0 -> stay.
REQ-017 LOAD: ld=1, acc_clr=1 for exactly one cycle; cnt<=0; -> TEST.
REQ-018 TEST: acc_add=lsb_in (combinational from lsb_in); -> SHIFT.
REQ-019 SHIFT: shr_en=1, shl_en=1 for one cycle; cnt<=cnt+1; cnt==WIDTH-1 -> DONE, else -> TEST.
REQ-020 DONE: done=1 for exactly one cycle; -> IDLE; cnt holds WIDTH.
REQ-021 All outputs except acc_add SHALL be pure decodes of state (Moore).
REQ-022 ld, shr_en, acc_add SHALL be mutually exclusive in every cycle; shl_en==shr_en always.
REQ-023 Latency: start sampled high in IDLE at cycle k -> LOAD at k+1, done high at k+2+2*WIDTH (k+34 for WIDTH=16).
REQ-024 start while busy=1 SHALL be ignored; no queuing, no restart.
REQ-025 start held high continuously SHALL produce back-to-back runs separated by exactly one IDLE cycle.
REQ-026 Exactly WIDTH acc_add evaluations and WIDTH shift strobes per run (no early termination).

Reset
REQ-027 rst=0 at a rising edge SHALL force IDLE, cnt=0, all strobes/busy/done=0 on the next cycle, from any state including mid-run.
REQ-028 No done pulse SHALL be generated for a run aborted by reset.
REQ-029 After rst returns high the block SHALL wait in IDLE for a fresh start.

Configuration
REQ-030 Macro SHIFT_MULT_EARLY_TERM_EN defined: in TEST, mplr_zero=1 -> DONE directly, acc_add=0, no shift strobe in that cycle; cnt holds its current value.
REQ-031 Macro undefined: mplr_zero SHALL be ignored; behaviour exactly per REQ-015..REQ-026.

Verification
REQ-032 Reset: rst=0 asserted in SHIFT with cnt=7 -> next cycle state IDLE, cnt=0, busy=0, done=0, all strobes 0; no done afterwards.
REQ-033 Nominal: WIDTH=16, start pulse at cycle 0, lsb_in driven from a model shifting 0xA5A5 right on shr_en -> ld at cycle 1, acc_add high in 8 TEST cycles matching set bits, 16 shr_en pulses, done at cycle 34, cnt=16.
REQ-034 Busy collision: second start pulse at cycle 10 of a run -> ignored, single done at cycle 34, next ld only after a new start.
REQ-035 Back-to-back: start held high from cycle 0 -> done at 34, IDLE at 35, ld at 36, done at 69.
REQ-036 Early termination: macro defined, mplr_zero=1 from cycle 2 -> done at cycle 3, zero shr_en pulses; macro undefined, same stimulus -> done at cycle 34.
REQ-037 Exclusivity checker: across all scenarios ld, shr_en, acc_add never simultaneously high; shl_en always equals shr_en.
